// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshaked data-memory responder.
// Holds the FSM state encoding, bus widths and the request fault check.
package dmem_pkg;

  localparam int DMEM_WORD_W = 32;
  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_LANES  = DMEM_WORD_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // A request faults when it is misaligned, addresses past the last word,
  // is not exactly one of load/store, or (with lane enables) stores no lanes.
  // The word index is compared at full width so high address bits never wrap.
  function automatic logic dmem_req_error(
    input logic [DMEM_ADDR_W-1:0] addr,
    input logic                   mem_read,
    input logic                   mem_write,
    input logic [DMEM_LANES-1:0]  byte_en,
    input logic                   be_check,
    input int unsigned            depth
  );
    logic [DMEM_ADDR_W-1:0] word_idx;
    logic misaligned;
    logic out_of_range;
    logic bad_op;
    logic empty_store;
    word_idx     = {2'b00, addr[DMEM_ADDR_W-1:2]};
    misaligned   = |addr[1:0];
    out_of_range = (word_idx >= depth);
    bad_op       = (mem_read == mem_write);
    empty_store  = be_check && mem_write && (byte_en == '0);
    return misaligned | out_of_range | bad_op | empty_store;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32-bit word storage for dmem_responder.
// Synchronous lane-masked write, combinational read, synchronous clear on RESET.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   wr_en_i,
  input  logic [IDX_W-1:0]       wr_idx_i,
  input  logic [DMEM_WORD_W-1:0] wr_data_i,
  input  logic [DMEM_LANES-1:0]  wr_mask_i,
  input  logic [IDX_W-1:0]       rd_idx_i,
  output logic [DMEM_WORD_W-1:0] rd_data_o
);

  logic [DMEM_WORD_W-1:0] mem_q [DEPTH];

  // Clear every word on reset; otherwise merge the enabled byte lanes into the addressed word.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      for (int b = 0; b < DMEM_LANES; b++) begin
        if (wr_mask_i[b]) begin
          mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end
  end

  // Combinational read; an index past the last word reads as zero.
  always_comb begin
    rd_data_o = '0;
    if ({1'b0, rd_idx_i} < (IDX_W+1)'(DEPTH)) begin
      rd_data_o = mem_q[rd_idx_i];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the core's data-memory interface: one handshaked,
// multi-cycle word access per request, with access-fault reporting.
// Optional: define DMEM_BYTE_ENABLE_EN to add the Byte_en port (per-lane
// store enables; an all-zero Byte_en on a store faults).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   Req_valid,
  output logic                   Req_ready,
  input  logic [DMEM_ADDR_W-1:0] Address,
  input  logic [DMEM_WORD_W-1:0] Write_data,
  input  logic                   MemWrite,
  input  logic                   MemRead,
`ifdef DMEM_BYTE_ENABLE_EN
  input  logic [DMEM_LANES-1:0]  Byte_en,
`endif
  output logic                   Resp_valid,
  input  logic                   Resp_ready,
  output logic [DMEM_WORD_W-1:0] Read_data,
  output logic                   Resp_error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = ($clog2(WAIT_CYCLES + 1) > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  dmem_state_e            state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   req_ready_q;
  logic                   resp_valid_q;
  logic [DMEM_WORD_W-1:0] rdata_q;
  logic                   err_q;

  logic [DMEM_ADDR_W-1:0] addr_q;
  logic [DMEM_WORD_W-1:0] wdata_q;
  logic                   wr_q;
  logic                   rd_q;
`ifdef DMEM_BYTE_ENABLE_EN
  logic [DMEM_LANES-1:0]  be_q;
`endif

  logic                   accept;
  logic                   handshake;
  logic                   commit;
  logic [DMEM_ADDR_W-1:0] cur_addr;
  logic [DMEM_WORD_W-1:0] cur_wdata;
  logic                   cur_wr;
  logic                   cur_rd;
  logic [DMEM_LANES-1:0]  cur_be;
  logic                   cur_be_check;
  logic                   cur_err;
  logic [IDX_W-1:0]       cur_idx;
  logic [DMEM_WORD_W-1:0] mem_rdata;
  logic [DMEM_WORD_W-1:0] rdata_d;
  logic                   err_d;

  assign accept    = Req_valid && req_ready_q;
  assign handshake = resp_valid_q && Resp_ready;

  // With zero wait states the commit lands on the accept edge itself, so the
  // commit path reads the live request in IDLE and the latched copy otherwise.
  always_comb begin
    cur_addr     = addr_q;
    cur_wdata    = wdata_q;
    cur_wr       = wr_q;
    cur_rd       = rd_q;
    cur_be       = '1;
    cur_be_check = 1'b0;
`ifdef DMEM_BYTE_ENABLE_EN
    cur_be       = be_q;
    cur_be_check = 1'b1;
`endif
    if (state_q == IDLE) begin
      cur_addr  = Address;
      cur_wdata = Write_data;
      cur_wr    = MemWrite;
      cur_rd    = MemRead;
`ifdef DMEM_BYTE_ENABLE_EN
      cur_be    = Byte_en;
`endif
    end
  end

  assign cur_idx = cur_addr[IDX_W+1:2];
  assign cur_err = dmem_req_error(cur_addr, cur_rd, cur_wr, cur_be, cur_be_check, DEPTH);
  assign commit  = ((state_q == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                   ((state_q == BUSY) && (cnt_q == CNT_LAST));
  assign rdata_d = (cur_rd && !cur_err) ? mem_rdata : '0;
  assign err_d   = cur_err;

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .CLK      (CLK),
    .RESET    (RESET),
    .wr_en_i  (commit && cur_wr && !cur_err),
    .wr_idx_i (cur_idx),
    .wr_data_i(cur_wdata),
    .wr_mask_i(cur_be),
    .rd_idx_i (cur_idx),
    .rd_data_o(mem_rdata)
  );

  // Capture the request on accept; pure datapath, so no reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      addr_q  <= Address;
      wdata_q <= Write_data;
      wr_q    <= MemWrite;
      rd_q    <= MemRead;
`ifdef DMEM_BYTE_ENABLE_EN
      be_q    <= Byte_en;
`endif
    end
  end

  // Request/response FSM with wait counter and registered handshake outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            if (commit) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              rdata_q      <= rdata_d;
              err_q        <= err_d;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (commit) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (handshake) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b0;
          resp_valid_q <= 1'b0;
          rdata_q      <= '0;
          err_q        <= 1'b0;
        end
      endcase
    end
  end

  assign Req_ready  = req_ready_q;
  assign Resp_valid = resp_valid_q;
  assign Read_data  = rdata_q;
  assign Resp_error = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0
// instance share the request inputs and Resp_ready, and are both checked
// against a word-array reference model.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int DEPTH = 16;
  localparam int WC    = 2;
`ifdef DMEM_BYTE_ENABLE_EN
  localparam bit BE_EN = 1'b1;
`else
  localparam bit BE_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        Req_valid;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemWrite;
  logic        MemRead;
  logic        Resp_ready;
`ifdef DMEM_BYTE_ENABLE_EN
  logic [3:0]  Byte_en;
`endif
  logic        Req_ready,  Resp_valid,  Resp_error;
  logic [31:0] Read_data;
  logic        Req_ready0, Resp_valid0, Resp_error0;
  logic [31:0] Read_data0;

  always #5 CLK = ~CLK;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
    .CLK(CLK), .RESET(RESET), .Req_valid(Req_valid), .Req_ready(Req_ready),
    .Address(Address), .Write_data(Write_data), .MemWrite(MemWrite), .MemRead(MemRead),
`ifdef DMEM_BYTE_ENABLE_EN
    .Byte_en(Byte_en),
`endif
    .Resp_valid(Resp_valid), .Resp_ready(Resp_ready), .Read_data(Read_data),
    .Resp_error(Resp_error)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .Req_valid(Req_valid), .Req_ready(Req_ready0),
    .Address(Address), .Write_data(Write_data), .MemWrite(MemWrite), .MemRead(MemRead),
`ifdef DMEM_BYTE_ENABLE_EN
    .Byte_en(Byte_en),
`endif
    .Resp_valid(Resp_valid0), .Resp_ready(Resp_ready), .Read_data(Read_data0),
    .Resp_error(Resp_error0)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] model_mem [DEPTH];

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    logic        r;
    logic [3:0]  be;
    int          hold;
    logic        e;
    logic [31:0] rd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit model_err(input logic [31:0] a, input logic w, input logic r,
                                   input logic [3:0] be);
    bit e;
    e = (a % 4 != 0) || ((a / 4) >= DEPTH) || (w == r);
    if (BE_EN && w && be == 4'b0000) e = 1'b1;
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
  endtask

  // One full transaction on both instances: wait ready, issue, measure latency,
  // compare the response, optionally stall Resp_ready, then complete the handshake.
  task automatic xact(input logic [31:0] a, input logic [31:0] d, input logic w,
                      input logic r, input logic [3:0] be, input int hold,
                      input string nm, output logic [31:0] got_rd, output logic got_err);
    int guard, lat, lat0, idx;
    bit e;
    logic [31:0] exp_rd, held_rd, mask;
    logic held_err;
    got_rd = 32'hx;
    got_err = 1'bx;
    guard = 0;
    while (!Req_ready && guard < 30) begin
      @(negedge CLK);
      guard++;
    end
    chk({nm, ":ready"}, 32'(Req_ready), 32'd1);
    chk({nm, ":ready0"}, 32'(Req_ready0), 32'd1);
    if (!Req_ready) return;
    Address = a; Write_data = d; MemWrite = w; MemRead = r;
`ifdef DMEM_BYTE_ENABLE_EN
    Byte_en = be;
`endif
    Req_valid = 1'b1;
    Resp_ready = 1'b0;
    @(negedge CLK);
    Req_valid = 1'b0;
    Address = $urandom; Write_data = $urandom;
    MemWrite = 1'($urandom); MemRead = 1'($urandom);
    chk({nm, ":ready_low"}, 32'(Req_ready), 32'd0);
    chk({nm, ":ready0_low"}, 32'(Req_ready0), 32'd0);
    lat = 1;
    lat0 = Resp_valid0 ? 1 : 0;
    while (!Resp_valid && lat < 30) begin
      @(negedge CLK);
      lat++;
      if (lat0 == 0 && Resp_valid0) lat0 = lat;
    end
    chk({nm, ":latency"}, 32'(lat), 32'(WC + 1));
    chk({nm, ":latency0"}, 32'(lat0), 32'd1);
    e = model_err(a, w, r, be);
    idx = int'(a >> 2);
    exp_rd = (!e && r) ? model_mem[idx] : 32'h0;
    chk({nm, ":rdata"}, Read_data, exp_rd);
    chk({nm, ":err"}, 32'(Resp_error), 32'(e));
    chk({nm, ":rdata0"}, Read_data0, exp_rd);
    chk({nm, ":err0"}, 32'(Resp_error0), 32'(e));
    got_rd = Read_data;
    got_err = Resp_error;
    if (!e && w) begin
      for (int b = 0; b < 4; b++) mask[8*b +: 8] = (!BE_EN || be[b]) ? 8'hFF : 8'h00;
      model_mem[idx] = (model_mem[idx] & ~mask) | (d & mask);
    end
    held_rd = Read_data;
    held_err = Resp_error;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      chk({nm, ":hold_valid"}, 32'(Resp_valid), 32'd1);
      chk({nm, ":hold_rdata"}, Read_data, held_rd);
      chk({nm, ":hold_err"}, 32'(Resp_error), 32'(held_err));
      chk({nm, ":hold_ready"}, 32'(Req_ready), 32'd0);
      chk({nm, ":hold_valid0"}, 32'(Resp_valid0), 32'd1);
    end
    Resp_ready = 1'b1;
    @(negedge CLK);
    Resp_ready = 1'b0;
    chk({nm, ":done_valid"}, 32'(Resp_valid), 32'd0);
    chk({nm, ":done_ready"}, 32'(Req_ready), 32'd1);
    chk({nm, ":done_rdata"}, Read_data, 32'h0);
    chk({nm, ":done_valid0"}, 32'(Resp_valid0), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[$];
    logic [31:0] rd_o;
    logic err_o;
    logic [31:0] a;
    logic [3:0] be;
    logic w, r;
    int sel, op;

    RESET = 1'b1; Req_valid = 1'b0; Address = '0; Write_data = '0;
    MemWrite = 1'b0; MemRead = 1'b0; Resp_ready = 1'b0;
`ifdef DMEM_BYTE_ENABLE_EN
    Byte_en = 4'hF;
`endif
    model_clear();
    repeat (3) @(negedge CLK);
    chk("rst:req_ready", 32'(Req_ready), 32'd0);
    chk("rst:resp_valid", 32'(Resp_valid), 32'd0);
    chk("rst:rdata", Read_data, 32'h0);
    chk("rst:err", 32'(Resp_error), 32'd0);
    chk("rst:resp_valid0", 32'(Resp_valid0), 32'd0);
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst:ready_after", 32'(Req_ready), 32'd1);

    // Directed table: store/load, misaligned, out of range, bad op, no-wrap, stall.
    tab.push_back('{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 4'hF, 0, 1'b0, 32'h0});
    tab.push_back('{32'h0000_0010, 32'h0,         1'b0, 1'b1, 4'hF, 0, 1'b0, 32'hDEAD_BEEF});
    tab.push_back('{32'h0000_0012, 32'h0,         1'b0, 1'b1, 4'hF, 0, 1'b1, 32'h0});
    tab.push_back('{32'h0000_0010, 32'h0,         1'b0, 1'b1, 4'hF, 0, 1'b0, 32'hDEAD_BEEF});
    tab.push_back('{32'h0000_0040, 32'h5555_5555, 1'b1, 1'b0, 4'hF, 0, 1'b1, 32'h0});
    tab.push_back('{32'h0000_0010, 32'h6666_6666, 1'b1, 1'b1, 4'hF, 0, 1'b1, 32'h0});
    tab.push_back('{32'h0000_0010, 32'h7777_7777, 1'b0, 1'b0, 4'hF, 0, 1'b1, 32'h0});
    tab.push_back('{32'h0000_0010, 32'h0,         1'b0, 1'b1, 4'hF, 5, 1'b0, 32'hDEAD_BEEF});
    tab.push_back('{32'h0000_003C, 32'hCAFE_F00D, 1'b1, 1'b0, 4'hF, 0, 1'b0, 32'h0});
    tab.push_back('{32'h0000_003C, 32'h0,         1'b0, 1'b1, 4'hF, 1, 1'b0, 32'hCAFE_F00D});
    tab.push_back('{32'h4000_0010, 32'h1234_0000, 1'b1, 1'b0, 4'hF, 0, 1'b1, 32'h0});
    tab.push_back('{32'h0000_0010, 32'h0,         1'b0, 1'b1, 4'hF, 0, 1'b0, 32'hDEAD_BEEF});
    tab.push_back('{32'h4000_003C, 32'h0,         1'b0, 1'b1, 4'hF, 0, 1'b1, 32'h0});
    foreach (tab[i]) begin
      xact(tab[i].a, tab[i].d, tab[i].w, tab[i].r, tab[i].be, tab[i].hold,
           $sformatf("tab%0d", i), rd_o, err_o);
      chk($sformatf("tab%0d:exp_rdata", i), rd_o, tab[i].rd);
      chk($sformatf("tab%0d:exp_err", i), 32'(err_o), 32'(tab[i].e));
    end

    // Reset while a store is waiting in BUSY: no response, memory cleared.
    Address = 32'h20; Write_data = 32'h1234_5678; MemWrite = 1'b1; MemRead = 1'b0;
`ifdef DMEM_BYTE_ENABLE_EN
    Byte_en = 4'hF;
`endif
    Req_valid = 1'b1;
    @(negedge CLK);
    Req_valid = 1'b0;
    chk("abort:busy_ready", 32'(Req_ready), 32'd0);
    chk("abort:busy_valid", 32'(Resp_valid), 32'd0);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("abort:valid", 32'(Resp_valid), 32'd0);
    chk("abort:valid0", 32'(Resp_valid0), 32'd0);
    chk("abort:ready", 32'(Req_ready), 32'd0);
    model_clear();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk($sformatf("abort:no_resp%0d", i), 32'(Resp_valid), 32'd0);
    end
    chk("abort:ready_back", 32'(Req_ready), 32'd1);
    xact(32'h20, 32'h0, 1'b0, 1'b1, 4'hF, 0, "abort_load", rd_o, err_o);
    chk("abort_load:zero", rd_o, 32'h0);
    xact(32'h10, 32'h0, 1'b0, 1'b1, 4'hF, 0, "abort_load10", rd_o, err_o);
    chk("abort_load10:zero", rd_o, 32'h0);

`ifdef DMEM_BYTE_ENABLE_EN
    // Lane-masked stores.
    xact(32'h8, 32'h1122_3344, 1'b1, 1'b0, 4'hF, 0, "be_full", rd_o, err_o);
    xact(32'h8, 32'hAABB_CCDD, 1'b1, 1'b0, 4'b0101, 0, "be_part", rd_o, err_o);
    xact(32'h8, 32'h0, 1'b0, 1'b1, 4'b0000, 0, "be_load", rd_o, err_o);
    chk("be_load:value", rd_o, 32'h11BB_33DD);
    xact(32'h8, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'b0000, 0, "be_zero", rd_o, err_o);
    chk("be_zero:err", 32'(err_o), 32'd1);
    xact(32'h8, 32'h0, 1'b0, 1'b1, 4'hF, 0, "be_reload", rd_o, err_o);
    chk("be_reload:value", rd_o, 32'h11BB_33DD);
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 60; k++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       a = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (sel == 7) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else if (sel == 8) a = 32'(DEPTH * 4 + $urandom_range(0, 15) * 4);
      else               a = ($urandom | 32'h8000_0000) & 32'hFFFF_FFFC;
      op = int'($urandom_range(0, 9));
      w = (op < 4) || (op == 8);
      r = ((op >= 4) && (op < 8)) || (op == 8);
      be = 4'($urandom_range(0, 15));
      xact(a, $urandom, w, r, be, int'($urandom_range(0, 2)),
           $sformatf("rnd%0d", k), rd_o, err_o);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
